// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell and a
// registered borrow produce diff = a - b LSB first, one bit per clock.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       state
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             bor;
  logic             a_msb;
  logic             b_msb;
  logic             x;
  logic             y;
  logic             d;
  logic             bout;
  logic             last;

  // Handshake: a start is accepted on any rising edge where start=1 and
  // busy=0 (IDLE or the DONE cycle); a and b are sampled only on that edge.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_comb begin
    x        = a_sh[0];
    y        = b_sh[0];
    d        = x ^ y ^ bor;
    bout     = (~x & y) | (~(x ^ y) & bor);
    res_next = {d, res[WIDTH-1:1]};
    last     = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      cnt      <= '0;
      bor      <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            res   <= '0;
            bor   <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          res  <= res_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bor  <= bout;
          cnt  <= cnt + CW'(1);
          // Visible results change only here, so they hold through SHIFT.
          if (last) begin
            diff     <= res_next;
            borrow   <= bout;
            zero     <= (res_next == '0);
            overflow <= (a_msb != b_msb) && (d != a_msb);
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes diff = a - b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Area-cheap arithmetic companion to the ripple adder chain, for ALU paths where a multi-cycle subtract is acceptable.
- Operands are captured on a start handshake; results are reported with a one-cycle done pulse plus status flags.

Parameters:
- WIDTH, 16, operand and result width in bits; legal range is 2 or more.

Ports:
- clock  input  1  single rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new subtraction; accepted only when busy=0
- a  input  WIDTH  minuend, sampled on the accepting edge only
- b  input  WIDTH  subtrahend, sampled on the accepting edge only
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  unsigned borrow out: 1 if a < b unsigned
- overflow  output  1  signed overflow of a - b
- zero  output  1  1 if diff == 0

Behaviour:
- Reset: clock and reset are as decided above. Reset asserted forces state IDLE immediately, independent of the clock.
  - busy, done, diff, borrow, overflow and zero all reset to 0.
  - Internal shift registers, borrow flip-flop and bit counter reset to 0.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1 at a rising edge (accepting edge E0):
  - Load a and b into the operand shift registers.
  - Clear the borrow flip-flop and the counter.
  - Go to SHIFT; busy=1 after E0.
  - start with busy=0 is the only accept condition, so a start during the done cycle is accepted back-to-back.
- IDLE or DONE with start=0: go to IDLE.
- SHIFT, one bit per edge E1..E_WIDTH, with x = LSB of a_sh, y = LSB of b_sh, bin = borrow FF:
  - d = x ^ y ^ bin.
  - bout = (~x & y) | (~(x ^ y) & bin).
  - d is shifted into the result register from the MSB side.
  - a_sh and b_sh shift right by one.
  - borrow FF <= bout; counter increments.
- On edge E_WIDTH (last bit):
  - Register diff with the final bit included, borrow = bout, zero = (diff == 0).
  - overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operand MSBs.
  - Go to DONE. busy=0 and done=1 for exactly one cycle after E_WIDTH.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH+1 rising edges after the accepting edge, counting the accepting edge E0.
- Result holding:
  - diff, borrow, overflow and zero hold their values until the next completion or reset.
  - These outputs do not change during SHIFT; the partial result lives only in an internal register.
- start is ignored while busy=1. a and b are don't-care except at the accepting edge.
- Reset mid-operation aborts the operation:
  - No done pulse is produced.
  - All outputs return to 0.
  - The next start is handled normally.
- Counter width is clog2(WIDTH)+1; no wrap-around occurs inside an operation.

Test Plan:
- WIDTH=16; start with a=5, b=3 -> done exactly 17 edges after the accepting edge; diff=0x0002, borrow=0, overflow=0, zero=0.
- a=3, b=5 -> diff=0xFFFE, borrow=1, overflow=0, zero=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, overflow=1. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, overflow=1.
- a=0x1234, b=0x1234 -> diff=0x0000, zero=1, borrow=0. Also check that outputs hold these values for 10 idle cycles after done.
- start a=9, b=4, then pulse start with a=0xFFFF, b=0 at cycle 5 while busy -> the second start is ignored; result diff=0x0005. Then assert start during the done cycle with a=1, b=2 -> the op is accepted back-to-back; diff=0xFFFF, borrow=1.
- Assert reset at cycle 8 of an operation -> busy, done, diff and flags go to 0 asynchronously with no done pulse. After reset release, a=10, b=7 -> diff=0x0003.
